// File: rtl/wr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wr_req_arbiter
// Description : Round-robin arbiter that issues cache-line writes from
//               NUM_REQ requesters and tracks outstanding writes per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_req_arbiter #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int NUM_REQ     = 4,
    parameter int MAX_OUT     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_LMT-1:0]     req_addr,
    input  logic [NUM_REQ*CACHE_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [ADDR_LMT-1:0]             wr_req_addr,
    output logic [MDATA-1:0]                wr_req_mdata,
    output logic [CACHE_WIDTH-1:0]          wr_req_data,
    output logic                            wr_req_en,
    input  logic                            wr_req_almostfull,
    input  logic                            wr_rsp0_valid,
    input  logic [MDATA-1:0]                wr_rsp0_mdata,
    input  logic                            wr_rsp1_valid,
    input  logic [MDATA-1:0]                wr_rsp1_mdata,
    output logic [NUM_REQ*4-1:0]            out_cnt,
    output logic                            done,
    output logic                            err
);

    localparam int         c_CW  = 4;
    localparam logic [3:0] c_MAX = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CW-1:0]        r_cnt [NUM_REQ];
    logic [c_CW-1:0]        w_cnt_nxt [NUM_REQ];
    logic [1:0]             w_dec [NUM_REQ];
    logic [c_CW-1:0]        w_sub [NUM_REQ];
    logic [NUM_REQ-1:0]     w_ovf;
    logic [NUM_REQ-1:0]     w_elig;
    logic [NUM_REQ-1:0]     w_gnt;
    logic                   w_found;
    logic [1:0]             w_win;
    logic [1:0]             r_ptr;
    logic [11:0]            r_issue;
    logic [MDATA-3:0]       w_seq;
    logic [ADDR_LMT-1:0]    w_sel_addr;
    logic [CACHE_WIDTH-1:0] w_sel_data;
    logic                   w_all_zero;
    logic                   r_wr_en;
    logic [ADDR_LMT-1:0]    r_wr_addr;
    logic [MDATA-1:0]       r_wr_mdata;
    logic [CACHE_WIDTH-1:0] r_wr_data;
    logic                   r_done;
    logic                   r_err;
    logic                   w_unused;

    // Only the requester id bits of a response tag are meaningful here.
    assign w_unused = ^{wr_rsp0_mdata[MDATA-1:2], wr_rsp1_mdata[MDATA-1:2]};

    generate
        if (MDATA - 2 <= 12) begin : g_seq_trunc
            assign w_seq = r_issue[MDATA-3:0];
        end else begin : g_seq_ext
            assign w_seq = {{(MDATA-14){1'b0}}, r_issue};
        end
    endgenerate

    // Eligibility, round-robin search from r_ptr, and winner data mux.
    always_comb begin
        w_elig     = '0;
        w_gnt      = '0;
        w_found    = 1'b0;
        w_win      = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = !rst && (r_state == ST_RUN) && req_valid[i]
                        && (r_cnt[i] < c_MAX) && !wr_req_almostfull;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_elig[2'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_found = 1'b1;
                w_win   = 2'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt[i] = w_found && (w_win == 2'(i));
            if (w_gnt[i]) begin
                w_sel_addr = req_addr[i*ADDR_LMT +: ADDR_LMT];
                w_sel_data = req_data[i*CACHE_WIDTH +: CACHE_WIDTH];
            end
        end
    end

    assign req_ready = w_gnt;

    // Net count update; responses beyond the current count are dropped.
    always_comb begin
        w_all_zero = 1'b1;
        w_ovf      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dec[i] = {1'b0, wr_rsp0_valid && (wr_rsp0_mdata[1:0] == 2'(i))}
                     + {1'b0, wr_rsp1_valid && (wr_rsp1_mdata[1:0] == 2'(i))};
            w_ovf[i] = ({2'b00, w_dec[i]} > r_cnt[i]);
            w_sub[i] = w_ovf[i] ? r_cnt[i] : {2'b00, w_dec[i]};
            w_cnt_nxt[i] = r_cnt[i] + {3'b000, w_gnt[i]} - w_sub[i];
            if (r_cnt[i] != '0) begin
                w_all_zero = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)      w_state_nxt = ST_RUN;
            ST_RUN:   if (flush)      w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_all_zero) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_issue    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_mdata <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= w_found;
            r_done  <= (r_state == ST_DRAIN) && w_all_zero;
            r_err   <= r_err | (|w_ovf);
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_found) begin
                r_wr_addr  <= w_sel_addr;
                r_wr_data  <= w_sel_data;
                r_wr_mdata <= {w_seq, w_win};
                r_issue    <= r_issue + 12'd1;
                r_ptr      <= 2'((int'(w_win) + 1) % NUM_REQ);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_out_cnt
            assign out_cnt[gi*4 +: 4] = r_cnt[gi];
        end
    endgenerate

    assign wr_req_en    = r_wr_en;
    assign wr_req_addr  = r_wr_addr;
    assign wr_req_mdata = r_wr_mdata;
    assign wr_req_data  = r_wr_data;
    assign done         = r_done;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: doc/wr_req_arbiter.md
WR_REQ_ARBITER -- requirements
Module: wr_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LMT, default 20, cache-line address width.
REQ-002 SHALL have parameter MDATA, default 14, request tag width.
REQ-003 SHALL have parameter CACHE_WIDTH, default 512, cache-line data width.
REQ-004 SHALL have parameter NUM_REQ, default 4, requester count; the id field is fixed at 2 bits.
REQ-005 SHALL have parameter MAX_OUT, default 8, per-requester outstanding-write limit.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port start, input, 1, pulse; IDLE->RUN.
REQ-009 SHALL have port flush, input, 1, pulse; RUN->DRAIN.
REQ-010 SHALL have port req_valid, input, NUM_REQ, per-requester line-write request.
REQ-011 SHALL have port req_addr, input, NUM_REQ*ADDR_LMT, addresses; requester i at slice i.
REQ-012 SHALL have port req_data, input, NUM_REQ*CACHE_WIDTH, line data; requester i at slice i.
REQ-013 SHALL have port req_ready, output, NUM_REQ, one-hot accept, combinational.
REQ-014 SHALL have port wr_req_addr, output, ADDR_LMT, registered address.
REQ-015 SHALL have port wr_req_mdata, output, MDATA, registered tag.
REQ-016 SHALL have port wr_req_data, output, CACHE_WIDTH, registered data.
REQ-017 SHALL have port wr_req_en, output, 1, registered one-cycle issue strobe.
REQ-018 SHALL have port wr_req_almostfull, input, 1, downstream backpressure.
REQ-019 SHALL have ports wr_rsp0_valid/wr_rsp1_valid, input, 1 each, completion strobes.
REQ-020 SHALL have ports wr_rsp0_mdata/wr_rsp1_mdata, input, MDATA each, completion tags.
REQ-021 SHALL have port out_cnt, output, NUM_REQ*4, per-requester outstanding count.
REQ-022 SHALL have port done, output, 1, one-cycle pulse when DRAIN completes.
REQ-023 SHALL have port err, output, 1, sticky; set by a response to a requester with zero outstanding.

Function
REQ-024 SHALL implement states IDLE(0), RUN(1), DRAIN(2); IDLE->RUN on start; RUN->DRAIN on flush; DRAIN->IDLE when all out_cnt are 0; any other encoding->IDLE.
REQ-025 SHALL treat requester i as eligible in cycle t when state==RUN, req_valid[i]=1, out_cnt[i]<MAX_OUT and wr_req_almostfull=0.
REQ-026 SHALL grant at most one eligible requester per cycle, round-robin, searching upward (with wrap) from the index after the last winner; the pointer resets to 0, so requester 0 has first priority after reset.
REQ-027 SHALL assert req_ready[w] in the grant cycle only; requester w holds req_addr/req_data stable while req_valid is high.
REQ-028 SHALL, in cycle t+1 after grant, drive wr_req_en=1, wr_req_addr/wr_req_data = the winner's slice, and wr_req_mdata = {issue_cnt[MDATA-3:0], w[1:0]}.
REQ-029 SHALL keep issue_cnt as a 12-bit global counter that increments per issue and wraps from 4095 to 0.
REQ-030 SHALL hold wr_req_addr/wr_req_data/wr_req_mdata at their last values when wr_req_en=0.
REQ-031 SHALL increment out_cnt[w] in the grant cycle.
REQ-032 SHALL decrement out_cnt[id] for each valid response, with id = mdata[1:0].
REQ-033 SHALL, when both responses carry the same id, decrement that count by 2.
REQ-034 SHALL apply a same-cycle grant and responses as a net change.
REQ-035 SHALL never underflow out_cnt: a response to a zero count is dropped and sets err.
REQ-036 SHALL ignore start outside IDLE and flush outside RUN.
REQ-037 SHALL grant nothing in DRAIN and IDLE, while still processing responses.
REQ-038 SHALL pulse done in the cycle DRAIN->IDLE registers; DRAIN with all counts already 0 exits after 1 cycle.

Reset
REQ-039 SHALL, while rst=1, clear state (IDLE), out_cnt, issue_cnt, the round-robin pointer, wr_req_en, wr_req_addr, wr_req_mdata, wr_req_data, done and err to 0, and hold req_ready=0.
REQ-040 SHALL, on reset mid-operation, discard in-flight tracking; responses arriving after reset are counted as underflow (err).

Verification
REQ-041 Single grant: start; req_valid=4'b0001, addr 0x00010 -> next cycle wr_req_en=1, addr 0x00010, mdata 0x0000, out_cnt[0]=1.
REQ-042 Fairness: req_valid=4'b1111 held 8 cycles, no almostfull -> grant order 0,1,2,3,0,1,2,3; mdata low bits match.
REQ-043 Limit: requester 1 only, no responses -> exactly 8 issues; req_ready[1] stays 0 until one response with id 1 arrives, then one more issue.
REQ-044 Backpressure: almostfull=1 for 5 cycles with all requesters valid -> no req_ready or wr_req_en; resumes at the round-robin pointer.
REQ-045 Dual response: out_cnt[2]=2, rsp0 and rsp1 both tagged id 2 in the same cycle as a grant to requester 2 -> out_cnt[2]=1; a response to id 3 at count 0 -> err=1.
REQ-046 Drain: 3 outstanding, flush -> no grants; done pulses exactly once, one cycle after the last response; state back to IDLE.
